// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: shared state encoding, opcodes and float format defaults
package fp_addsub_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int EXP_DEF   = 8;
    localparam int MANT_DEF  = 23;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_e;
endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// fp_addsub_arbiter_if: request/response bus between requesters (master) and the shared add/sub unit (slave)
//   req_valid/req_ready/req_a/req_b/req_op : per-requester request channel, slice i = requester i
//   res_valid/res_ready/res_data/res_id    : single response channel
//   busy/op_count                          : status
interface fp_addsub_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]       req_valid, req_ready, req_op;
    logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
    logic                     res_valid, res_ready, busy;
    logic [WIDTH-1:0]         res_data;
    logic [ID_W-1:0]          res_id;
    logic [15:0]              op_count;
    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy, op_count
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_id, busy, op_count
    );
endinterface

// File: rtl/add_sub_main.sv
// add_sub_main: combinational float add/sub, truncating, no special-value handling
//   a, b             : operands
//   operation_select : 0 = a+b, 1 = a-b
//   result           : sum/difference
module add_sub_main import fp_addsub_pkg::*; #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_BITS  = EXP_DEF,
    parameter int MANT_BITS = MANT_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             operation_select,
    output logic [WIDTH-1:0] result
);
    // three guard bits below the mantissa plus one carry bit on top
    localparam int X = MANT_BITS + 4;
    logic                 swap, sl, ss, sb_eff;
    logic [EXP_BITS-1:0]  el, es, e, d;
    logic [MANT_BITS:0]   ml, ms;
    logic [X:0]           s, sh;
    always_comb begin
        sb_eff = b[WIDTH-1] ^ (operation_select == OP_SUB);
        swap   = b[WIDTH-2:0] > a[WIDTH-2:0];
        sl     = swap ? sb_eff : a[WIDTH-1];
        ss     = swap ? a[WIDTH-1] : sb_eff;
        el     = swap ? b[MANT_BITS +: EXP_BITS] : a[MANT_BITS +: EXP_BITS];
        es     = swap ? a[MANT_BITS +: EXP_BITS] : b[MANT_BITS +: EXP_BITS];
        ml     = {|el, swap ? b[MANT_BITS-1:0] : a[MANT_BITS-1:0]};
        ms     = {|es, swap ? a[MANT_BITS-1:0] : b[MANT_BITS-1:0]};
        d      = el - es;
        sh     = {1'b0, ms, 3'b000} >> d;
        s      = {1'b0, ml, 3'b000};
        s      = (sl == ss) ? s + sh : s - sh;
        e      = el;
        if (s[X]) begin
            s = s >> 1;
            e = e + 1'b1;
        end
        for (int i = 0; i < X; i++)
            if (!s[X-1] && s != '0 && e != '0) begin
                s = s << 1;
                e = e - 1'b1;
            end
        result = (s == '0) ? '0 : {sl, e, s[X-2 -: MANT_BITS]};
    end
endmodule

// File: rtl/fp_addsub_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr
//   req   : request vector
//   ptr   : highest-priority index
//   en    : grant allowed
//   grant : one-hot grant (zero when disabled or no request)
//   idx   : encoded winner index
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    always_comb begin
        idx = '0;
        // walk downward so the smallest distance from ptr is assigned last
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NUM_REQ]) idx = ID_W'((int'(ptr) + k) % NUM_REQ);
        grant = (en && |req) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: round-robin sharing of one registered float add/sub datapath
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of fp_addsub_arbiter_if (requests, response, busy, op_count)
module fp_addsub_arbiter import fp_addsub_pkg::*; #(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int EXP_BITS  = EXP_DEF,
    parameter int MANT_BITS = MANT_DEF,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input logic                clk,
    input logic                rst_n,
    fp_addsub_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = S_IDLE;
    localparam logic [1:0] EXEC = S_EXEC;
    localparam logic [1:0] DONE = S_DONE;
    logic [1:0]         state;
    logic [ID_W-1:0]    ptr, win, id_q, rid_q;
    logic [NUM_REQ-1:0] grant;
    logic [WIDTH-1:0]   a_q, b_q, sum, res_q;
    logic               op_q;
    logic [15:0]        op_cnt;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req(bus.req_valid), .ptr(ptr), .en(state == IDLE), .grant(grant), .idx(win)
    );
    add_sub_main #(.WIDTH(WIDTH), .EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)) u_fp (
        .a(a_q), .b(b_q), .operation_select(op_q), .result(sum)
    );
    assign bus.req_ready = grant;
    assign bus.res_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.res_data  = res_q;
    assign bus.res_id    = rid_q;
    assign bus.op_count  = op_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            id_q   <= '0;
            res_q  <= '0;
            rid_q  <= '0;
            op_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    a_q   <= bus.req_a[win*WIDTH +: WIDTH];
                    b_q   <= bus.req_b[win*WIDTH +: WIDTH];
                    op_q  <= bus.req_op[win];
                    id_q  <= win;
                    ptr   <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    res_q <= sum;
                    rid_q <= id_q;
                    state <= DONE;
                end
                DONE: if (bus.res_ready) begin
                    op_cnt <= op_cnt + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter: scoreboard bench for the shared add/sub arbiter
module tb_fp_addsub_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    fp_addsub_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
    fp_addsub_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    typedef struct { logic [31:0] d; logic [1:0] id; } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_op[i]       = op;
        bus.req_valid[i]    = 1'b1;
    endtask

    // call just after a negedge; returns at posedge+1 of the handshake edge
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic op, input logic [31:0] d);
        int n = 0;
        exp_t e;
        set_req(i, a, b, op);
        #1;
        while (!bus.req_ready[i] && n < 30) begin
            @(negedge clk); #1; n++;
        end
        total++;
        if (bus.req_ready !== 4'(1 << i)) begin
            bad++;
            $display("FAIL grant%0d: got %b want %b", i, bus.req_ready, 4'(1 << i));
        end
        e.d = d; e.id = 2'(i);
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic collect();
        int n = 0;
        exp_t e;
        while (!bus.res_valid && n < 30) begin
            @(negedge clk); n++;
        end
        total++;
        if (!bus.res_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL res_wait: got valid=%b queued=%0d want valid=1 queued>0", bus.res_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        total += 2;
        if (bus.res_data !== e.d) begin bad++; $display("FAIL res_data: got %h want %h", bus.res_data, e.d); end
        if (bus.res_id !== e.id) begin bad++; $display("FAIL res_id: got %0d want %0d", bus.res_id, e.id); end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            total += 6;
            if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.res_valid); end
            if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
            if (bus.op_count !== 16'h0) begin bad++; $display("FAIL rst_count: got %h want 0", bus.op_count); end
            if (bus.res_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", bus.res_data); end
            if (bus.res_id !== 2'd0) begin bad++; $display("FAIL rst_id: got %0d want 0", bus.res_id); end
            if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
            rst_n = 1'b1;
            #1;
        end
    endtask

    task automatic test_single_add();
        @(negedge clk);
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        total += 3;
        if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid: got %b want 0", bus.res_valid); end
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL add_busy: got %b want 1", bus.busy); end
        if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL add_exec_ready: got %b want 0", bus.req_ready); end
        @(posedge clk); #1;
        total++;
        if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL add_latency: got %b want 1", bus.res_valid); end
        collect();
        total += 2;
        if (bus.op_count !== 16'd1) begin bad++; $display("FAIL add_count: got %0d want 1", bus.op_count); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_single_sub();
        @(negedge clk);
        issue(2, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);
        collect();
        total++;
        if (bus.op_count !== 16'd2) begin bad++; $display("FAIL sub_count: got %0d want 2", bus.op_count); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        issue(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
        set_req(0, 32'h3F800000, 32'h3F800000, 1'b0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total += 5;
            if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", bus.res_valid); end
            if (bus.res_data !== 32'h40800000) begin bad++; $display("FAIL bp_data: got %h want 40800000", bus.res_data); end
            if (bus.res_id !== 2'd1) begin bad++; $display("FAIL bp_id: got %0d want 1", bus.res_id); end
            if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", bus.req_ready); end
            if (bus.op_count !== 16'd2) begin bad++; $display("FAIL bp_count: got %0d want 2", bus.op_count); end
        end
        collect();
        issue(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        collect();
        total++;
        if (bus.op_count !== 16'd4) begin bad++; $display("FAIL bp_count_after: got %0d want 4", bus.op_count); end
    endtask

    task automatic test_contention();
        logic [31:0] res_tab [4] = '{32'h40400000, 32'h40000000, 32'h0, 32'h40800000};
        int order [4] = '{0, 1, 3, 0};
        int g = 0, r = 0, cyc = 0, last = 0, id;
        bit stop = 0;
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        set_req(3, 32'h40000000, 32'h40000000, 1'b0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        while (r < 4 && cyc < 60) begin
            #1;
            if (|bus.req_ready && g < 4) begin
                id = 0;
                for (int k = 0; k < N; k++) if (bus.req_ready[k]) id = k;
                total += 2;
                if (!$onehot(bus.req_ready) || id != order[g]) begin bad++; $display("FAIL cont_order%0d: got %b want index %0d", g, bus.req_ready, order[g]); end
                if (g > 0 && cyc - last < 3) begin bad++; $display("FAIL cont_gap%0d: got %0d want >=3", g, cyc - last); end
                e.d = res_tab[id]; e.id = 2'(id);
                sb.push_back(e);
                last = cyc;
                g++;
                stop = (g == 4);
            end
            if (bus.res_valid) begin
                e = sb.pop_front();
                total += 2;
                if (bus.res_data !== e.d) begin bad++; $display("FAIL cont_data: got %h want %h", bus.res_data, e.d); end
                if (bus.res_id !== e.id) begin bad++; $display("FAIL cont_id: got %0d want %0d", bus.res_id, e.id); end
                r++;
            end
            @(negedge clk);
            cyc++;
            if (stop) bus.req_valid = '0;
        end
        bus.res_ready = 1'b0;
        total += 2;
        if (g != 4 || r != 4) begin bad++; $display("FAIL cont_progress: got grants=%0d results=%0d want 4/4", g, r); end
        if (bus.op_count !== 16'd4) begin bad++; $display("FAIL cont_count: got %0d want 4", bus.op_count); end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        issue(0, 32'h40800000, 32'h3F800000, 1'b1, 32'h40400000);
        void'(sb.pop_back());
        rst_n = 1'b0;
        #1;
        total += 4;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rx_busy: got %b want 0", bus.busy); end
        if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rx_valid: got %b want 0", bus.res_valid); end
        if (bus.res_data !== 32'h0) begin bad++; $display("FAIL rx_data: got %h want 0", bus.res_data); end
        if (bus.op_count !== 16'h0) begin bad++; $display("FAIL rx_count: got %0d want 0", bus.op_count); end
        repeat (2) begin
            @(negedge clk);
            total++;
            if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rx_pulse: got %b want 0", bus.res_valid); end
        end
        set_req(1, 32'h40000000, 32'h3F800000, 1'b0);
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        rst_n = 1'b1;
        #1;
        total += 2;
        if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rx_first: got %b want 0001", bus.req_ready); end
        if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL rx_after_valid: got %b want 0", bus.res_valid); end
        issue(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
        bus.req_valid[1] = 1'b0;
        collect();
        total++;
        if (bus.op_count !== 16'd1) begin bad++; $display("FAIL rx_count_after: got %0d want 1", bus.op_count); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.op_cnt;
        #1;
        total++;
        if (bus.op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload: got %h want ffff", bus.op_count); end
        @(negedge clk);
        issue(3, 32'h3F800000, 32'h3F800000, 1'b1, 32'h0);
        collect();
        total++;
        if (bus.op_count !== 16'h0) begin bad++; $display("FAIL wrap_count: got %h want 0000", bus.op_count); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_single_sub();
        test_backpressure();
        test_contention();
        test_reset_exec();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_arbiter.md
Name: fp_addsub_arbiter

Overview:
- Shares one combinational FP add/sub datapath (add_sub_main: a, b, operation_select, result) among NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- One operation in flight at a time. Operands and result are registered, so the combinational datapath sits between two register stages.
- Sits between the requesting units (e.g. FP issue slots) and the add/sub datapath.

Parameters:
- WIDTH, 32, total float width
- EXP_BITS, 8, exponent width (passed to add_sub_main)
- MANT_BITS, 23, mantissa width (passed to add_sub_main)
- NUM_REQ, 4, number of requesters; legal range 2..8
- ID_W, $clog2(NUM_REQ), requester index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A; slice i belongs to requester i
- req_b  in  NUM_REQ*WIDTH  operand B; slice i belongs to requester i
- req_op  in  NUM_REQ  operation: 0 = add, 1 = subtract (A-B)
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  registered result
- res_id  out  ID_W  index of the requester that issued the result
- busy  out  1  high in any state other than IDLE
- op_count  out  16  count of completed (accepted) results; wraps at 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync deassert) drives every register to its reset value:
  - state = IDLE, res_valid = 0, res_data = 0, res_id = 0, busy = 0, op_count = 0.
  - Operand registers = 0; round-robin pointer = 0, so requester 0 has highest priority.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready is combinational. It is one-hot on the winning index when any req_valid is high, otherwise all zero.
  - Winner: the first i with req_valid[i] set, searching upward from ptr modulo NUM_REQ.
  - On the clock edge with a handshake: capture the winner's a, b and op plus its index; set ptr = winner+1 modulo NUM_REQ; go to EXEC.
  - With no valid request, stay in IDLE; ptr is unchanged.
- EXEC:
  - Captured operands drive add_sub_main.
  - On the next edge: res_data <= result, res_id <= captured index; go to DONE.
  - req_ready = 0.
- DONE:
  - res_valid = 1; res_data and res_id stay stable until the handshake.
  - When res_valid & res_ready: op_count increments and the FSM returns to IDLE. res_valid deasserts on that edge.
  - req_ready = 0 throughout DONE, including the handshake cycle; there is no bypass to a new grant.
- Latency: 2 edges from request handshake to res_valid high. Minimum issue interval is 3 cycles.
- Requesters hold req_valid and operands stable until accepted. The block never drops a request. Withdrawing a request before it is accepted is legal and has no side effect.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others wait.
- Fairness: a continuously asserted request is granted within NUM_REQ grants.
- Reset asserted mid-operation (EXEC or DONE): the in-flight result is discarded, no res handshake occurs, op_count does not increment, and the FSM returns to IDLE.
- Arithmetic: fully delegated to add_sub_main. This block does no rounding or special-value handling.

Decomposition:
- Shared package fp_addsub_pkg:
  - state enum (IDLE, EXEC, DONE)
  - OP_ADD = 1'b0, OP_SUB = 1'b1
  - default WIDTH/EXP_BITS/MANT_BITS constants
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, ptr, enable; outputs one-hot grant and encoded index. Pure combinational.
- add_sub_main is instantiated inside this block as-is.

Test Plan:
1. Single add: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0 -> req_ready[0] in the same cycle; res_valid exactly 2 edges later; res_data=0x40400000, res_id=0, op_count=1.
2. Single subtract: req2 a=0x40400000, b=0x3F800000, op=1 -> res_data=0x40000000 (2.0), res_id=2.
3. Contention: req0, req1 and req3 all held valid from reset, res_ready tied high -> grant order 0, 1, 3, then 0 again. Each grant is at least 3 cycles after the previous one; op_count=4 after four results.
4. Backpressure: res_ready low for 5 cycles during DONE -> res_valid, res_data and res_id stable; req_ready=0 throughout; op_count unchanged until the handshake.
5. Reset in EXEC: assert rst_n=0 one cycle after a grant -> outputs immediately return to reset values; after release busy=0, res_valid never pulses for the dropped operation, and req0 is granted first.
6. op_count wrap: force 0xFFFF completed results (or preload via backdoor) then complete one more -> op_count=0x0000.
